// File: rtl/iomem_yanitlayici.sv
// Responder end of the iomem valid/ready bus: word memory behind BEKLEME wait states.
// Define IOMEM_YANIT_YAZMA_EN to commit byte-masked writes; otherwise the memory is read-only.
module iomem_yanitlayici #(
  parameter logic [31:0] ADRES_TABANI  = 32'h4000_0000,
  parameter int          BELLEK_KELIME = 1024,
  parameter int          BEKLEME       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        hata_o
);
  localparam int          IW  = $clog2(BELLEK_KELIME);
  localparam logic [32:0] ALT = {1'b0, ADRES_TABANI};
  localparam logic [32:0] UST = ALT + (33'(BELLEK_KELIME) << 2);
`ifdef IOMEM_YANIT_YAZMA_EN
  localparam bit YAZMA_EN = 1'b1;
`else
  localparam bit YAZMA_EN = 1'b0;
`endif

  typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

  durum_t      r_durum;
  logic [3:0]  r_sayac;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_mem [BELLEK_KELIME];

  logic          w_bosta;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic [32:0]   w_a33;
  logic [32:0]   w_ofs;
  logic          w_pencere;
  logic [IW-1:0] w_idx;
  logic          w_giris;
  logic [31:0]   w_eski;
  logic          w_unused;

  // With zero wait states the access is resolved straight from the bus inputs.
  assign w_bosta   = (r_durum == BOSTA);
  assign w_addr    = w_bosta ? iomem_addr  : r_addr;
  assign w_wdata   = w_bosta ? iomem_wdata : r_wdata;
  assign w_wstrb   = w_bosta ? iomem_wstrb : r_wstrb;
  assign w_a33     = {1'b0, w_addr[31:2], 2'b00};
  assign w_ofs     = w_a33 - ALT;
  assign w_pencere = (w_a33 >= ALT) && (w_a33 < UST);
  assign w_idx     = w_ofs[IW+1:2];
  assign w_eski    = r_mem[w_idx];
  assign w_unused  = ^{w_ofs[32:IW+2], w_ofs[1:0], w_addr[1:0]};

  // Edge that enters YANIT: outputs are loaded and the write committed here.
  assign w_giris = !rst_i && iomem_valid &&
                   ((w_bosta && BEKLEME == 0) || (r_durum == BEKLE && r_sayac == 4'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum     <= BOSTA;
      r_sayac     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      hata_o      <= 1'b0;
    end else begin
      iomem_ready <= 1'b0;
      if (w_giris) begin
        iomem_ready <= 1'b1;
        iomem_rdata <= w_pencere ? w_eski : 32'hDEAD_BEEF;
        hata_o      <= !w_pencere;
      end
      case (r_durum)
        BOSTA: if (iomem_valid) begin
          r_addr  <= iomem_addr;
          r_wdata <= iomem_wdata;
          r_wstrb <= iomem_wstrb;
          r_sayac <= 4'(BEKLEME);
          r_durum <= (BEKLEME == 0) ? YANIT : BEKLE;
        end
        BEKLE: begin
          if (!iomem_valid)         r_durum <= BOSTA;
          else if (r_sayac == 4'd1) r_durum <= YANIT;
          r_sayac <= r_sayac - 4'd1;
        end
        YANIT:   r_durum <= BOSTA;
        default: r_durum <= BOSTA;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (YAZMA_EN && w_giris && w_pencere) begin
      for (int b = 0; b < 4; b++)
        if (w_wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_iomem_yanitlayici.sv
// Directed bench: instance A uses 2 wait states, instance B zero wait states.
module tb_iomem_yanitlayici;
`ifdef IOMEM_YANIT_YAZMA_EN
  localparam bit YZ = 1'b1;
`else
  localparam bit YZ = 1'b0;
`endif

  logic clk, rst;
  logic        a_valid, a_ready, a_hata;
  logic [3:0]  a_wstrb;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_ready, b_hata;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr, b_wdata, b_rdata;
  int checks = 0;
  int failures = 0;

  iomem_yanitlayici #(.ADRES_TABANI(32'h4000_0000), .BELLEK_KELIME(1024), .BEKLEME(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .iomem_valid(a_valid), .iomem_ready(a_ready),
    .iomem_wstrb(a_wstrb), .iomem_addr(a_addr), .iomem_wdata(a_wdata),
    .iomem_rdata(a_rdata), .hata_o(a_hata));

  iomem_yanitlayici #(.ADRES_TABANI(32'h4000_0000), .BELLEK_KELIME(1024), .BEKLEME(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .iomem_valid(b_valid), .iomem_ready(b_ready),
    .iomem_wstrb(b_wstrb), .iomem_addr(b_addr), .iomem_wdata(b_wdata),
    .iomem_rdata(b_rdata), .hata_o(b_hata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One transaction on instance A; lat = edges from sampling to ready visible, -1 if none.
  task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic hata, output int lat, output logic tail);
    a_valid = 1'b1; a_addr = addr; a_wstrb = wstrb; a_wdata = wdata;
    lat = -1; rdata = '0; hata = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (a_ready) begin lat = k; rdata = a_rdata; hata = a_hata; end
    end
    a_valid = 1'b0; a_wstrb = '0;
    tick();
    tail = a_ready;
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL %s got=%h exp=%h", nm, got, exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); tick();
    checks++;
    if ({a_ready, a_hata, a_rdata} !== 34'd0) begin
      failures++; $display("FAIL reset_a got=%b/%b/%h exp=0/0/0", a_ready, a_hata, a_rdata);
    end
    checks++;
    if ({b_ready, b_hata, b_rdata} !== 34'd0) begin
      failures++; $display("FAIL reset_b got=%b/%b/%h exp=0/0/0", b_ready, b_hata, b_rdata);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_read();
    logic [31:0] rd; logic h, t; int lat;
    txn(32'h4000_0014, 4'h0, 32'h0, rd, h, lat, t);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", lat); end
    chk32("read_data", rd, 32'h1234_5678);
    chk32("read_hata", {31'd0, h}, 32'd0);
    chk32("read_single_pulse", {31'd0, t}, 32'd0);
    chk32("read_rdata_hold", a_rdata, 32'h1234_5678);
    txn(32'h4000_0017, 4'h0, 32'h0, rd, h, lat, t);
    chk32("read_low_bits_ignored", rd, 32'h1234_5678);
  endtask

  task automatic test_window_edges();
    logic [31:0] rd; logic h, t; int lat;
    txn(32'h4000_0FFC, 4'h0, 32'h0, rd, h, lat, t);
    chk32("last_word", rd, 32'hCAFE_0FFF);
    chk32("last_word_hata", {31'd0, h}, 32'd0);
    txn(32'h4000_0000, 4'h0, 32'h0, rd, h, lat, t);
    chk32("first_word", rd, 32'hAABB_CCDD);
  endtask

  task automatic test_out_of_window();
    logic [31:0] rd; logic h, t; int lat;
    txn(32'h3FFF_FFFC, 4'h0, 32'h0, rd, h, lat, t);
    chk32("oob_below_data", rd, 32'hDEAD_BEEF);
    chk32("oob_below_hata", {31'd0, h}, 32'd1);
    txn(32'h4000_1000, 4'h0, 32'h0, rd, h, lat, t);
    chk32("oob_above_data", rd, 32'hDEAD_BEEF);
    chk32("oob_above_hata", {31'd0, h}, 32'd1);
    txn(32'h4000_1000, 4'hF, 32'h0123_4567, rd, h, lat, t);
    chk32("oob_write_hata", {31'd0, h}, 32'd1);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL oob_write_latency got=%0d exp=3", lat); end
    txn(32'h4000_0000, 4'h0, 32'h0, rd, h, lat, t);
    chk32("oob_write_no_alias", rd, 32'hAABB_CCDD);
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; logic h, t; int lat;
    txn(32'h4000_0000, 4'b0101, 32'h1122_3344, rd, h, lat, t);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL write_latency got=%0d exp=3", lat); end
    chk32("write_returns_old", rd, 32'hAABB_CCDD);
    txn(32'h4000_0000, 4'h0, 32'h0, rd, h, lat, t);
    chk32("write_readback", rd, YZ ? 32'hAA22_CC44 : 32'hAABB_CCDD);
  endtask

  task automatic test_back_to_back();
    b_valid = 1'b1; b_wstrb = 4'h0; b_addr = 32'h4000_000C; b_wdata = '0;
    tick();
    chk32("b2b_ready1", {31'd0, b_ready}, 32'd1);
    chk32("b2b_data1", b_rdata, 32'h3333_0003);
    b_addr = 32'h4000_0024;
    tick();
    chk32("b2b_gap", {31'd0, b_ready}, 32'd0);
    tick();
    chk32("b2b_ready2", {31'd0, b_ready}, 32'd1);
    chk32("b2b_data2", b_rdata, 32'h9999_0009);
    chk32("b2b_hata", {31'd0, b_hata}, 32'd0);
    b_valid = 1'b0;
    tick();
    chk32("b2b_end", {31'd0, b_ready}, 32'd0);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic h, t; int lat; int seen;
    seen = 0;
    a_valid = 1'b1; a_addr = 32'h4000_001C; a_wstrb = 4'hF; a_wdata = 32'hFFFF_FFFF;
    tick();
    a_valid = 1'b0; a_wstrb = '0;
    for (int k = 0; k < 6; k++) begin tick(); if (a_ready) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_no_ready got=%0d exp=0", seen); end
    txn(32'h4000_001C, 4'h0, 32'h0, rd, h, lat, t);
    chk32("abort_no_write", rd, 32'h7777_0007);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic h, t; int lat;
    a_valid = 1'b1; a_addr = 32'h4000_001C; a_wstrb = 4'hF; a_wdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b1; a_valid = 1'b0; a_wstrb = '0;
    tick();
    chk32("rstmid_ready", {31'd0, a_ready}, 32'd0);
    chk32("rstmid_rdata", a_rdata, 32'd0);
    chk32("rstmid_hata", {31'd0, a_hata}, 32'd0);
    rst = 1'b0;
    txn(32'h4000_001C, 4'h0, 32'h0, rd, h, lat, t);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL rstmid_idle_latency got=%0d exp=3", lat); end
    chk32("rstmid_no_write", rd, 32'h7777_0007);
  endtask

  task automatic test_rom_write();
    logic [31:0] rd; logic h, t; int lat;
    txn(32'h4000_0008, 4'hF, 32'hFFFF_FFFF, rd, h, lat, t);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL rom_latency got=%0d exp=3", lat); end
    chk32("rom_write_old", rd, 32'h0BAD_F00D);
    txn(32'h4000_0008, 4'h0, 32'h0, rd, h, lat, t);
    chk32("rom_readback", rd, YZ ? 32'hFFFF_FFFF : 32'h0BAD_F00D);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_wstrb = '0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_wstrb = '0; b_addr = '0; b_wdata = '0;
    dut_a.r_mem[0]    = 32'hAABB_CCDD;
    dut_a.r_mem[2]    = 32'h0BAD_F00D;
    dut_a.r_mem[5]    = 32'h1234_5678;
    dut_a.r_mem[7]    = 32'h7777_0007;
    dut_a.r_mem[1023] = 32'hCAFE_0FFF;
    dut_b.r_mem[3]    = 32'h3333_0003;
    dut_b.r_mem[9]    = 32'h9999_0009;
    test_reset();
    test_read();
    test_window_edges();
    test_out_of_window();
    test_byte_write();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_rom_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
